// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Bit-serial, LSB-first two's-complement subtractor computing diff = a - b,
//   one bit per clock. A single full-subtractor cell is reused every cycle and
//   the borrow between bit positions is carried in a flop. A start/busy/done
//   handshake lets a controller issue a request and wait WIDTH cycles for the
//   result.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      request pulse, only honoured while idle
//   a          in   WIDTH  minuend, sampled on the edge that accepts start
//   b          in   WIDTH  subtrahend, sampled on the edge that accepts start
//   busy       out  1      high while bits are being processed
//   done       out  1      one-cycle pulse; results valid from this cycle on
//   diff       out  WIDTH  a - b modulo 2^WIDTH
//   borrow_out out  1      unsigned borrow (a < b unsigned)
//   overflow   out  1      signed overflow of a - b
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    // Counter only has to reach WIDTH-1; the DONE transition happens on that
    // value, so the counter never needs to wrap.
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   a_sh_q,     a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,     b_sh_d;
    logic [WIDTH-1:0]   acc_q,      acc_d;
    logic               br_q,       br_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               a_msb_q,    a_msb_d;
    logic               b_msb_q,    b_msb_d;
    logic [WIDTH-1:0]   diff_q,     diff_d;
    logic               borrow_q,   borrow_d;
    logic               ovf_q,      ovf_d;

    // -----------------------------------------------------------------------
    // Full-subtractor cell for the current bit position
    // -----------------------------------------------------------------------
    logic             cell_d;      // difference bit
    logic             cell_br;     // borrow into the next bit position
    logic [WIDTH-1:0] acc_shift;   // accumulator with this bit shifted in at the MSB

    always_comb begin
        cell_d    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        // Borrow when a<b at this bit, or when the bits are equal and a borrow
        // is already pending from below.
        cell_br   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        acc_shift = {cell_d, acc_q[WIDTH-1:1]};
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    acc_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    // Operand signs are kept aside because the shift
                    // registers lose them before the overflow decision.
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d  = acc_shift;
                br_d   = cell_br;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d   = acc_shift;
                    borrow_d = cell_br;
                    // Signed overflow: operands of differing sign and a result
                    // whose sign differs from the minuend.
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers; reset wins over everything, discarding any partial result
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: handshake decoded straight from the state register, results
    // held in their own flops until the next completed operation.
    // -----------------------------------------------------------------------
    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule
